// File: rtl/pulse_timer.sv
// Pulse/gap length meter: times each phase of a filtered bit in en samples and
// hands completed phases to a single-entry valid/ready output slot.
module pulse_timer #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 bitIn,
    input  logic                 clrOvr,
    output logic                 outValid,
    input  logic                 outReady,
    output logic                 outLevel,
    output logic [CNT_WIDTH-1:0] outCount,
    output logic                 outSat,
    output logic                 overrun
);

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                 state_r, state_s;
    logic [CNT_WIDTH-1:0]   cnt_r, cnt_s;
    logic                   prev_r, prev_s;
    logic                   valid_r, valid_s;
    logic                   level_r, level_s;
    logic [CNT_WIDTH-1:0]   count_r, count_s;
    logic                   sat_r, sat_s;
    logic                   overrun_r, overrun_s;
    logic                   edge_s;
    logic                   slot_free_s;

    // Phase tracking: next state, counter and remembered level
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        prev_s  = prev_r;
        edge_s  = 1'b0;
        case (state_r)
            ST_INIT: begin
                if (en) begin
                    prev_s  = bitIn;
                    state_s = ST_IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            ST_IDLE: begin
                // The first phase started before we saw it, so it is never reported
                if (en && (bitIn != prev_r)) begin
                    state_s = ST_MEASURE;
                    cnt_s   = CNT_ONE;
                    prev_s  = bitIn;
                end else begin
                    state_s = state_r;
                end
            end
            ST_MEASURE: begin
                if (en && (bitIn != prev_r)) begin
                    edge_s = 1'b1;
                    cnt_s  = CNT_ONE;
                    prev_s = bitIn;
                end else if (en && (cnt_r != CNT_MAX)) begin
                    cnt_s = cnt_r + CNT_ONE;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = ST_INIT;
                cnt_s   = {CNT_WIDTH{1'b0}};
                prev_s  = 1'b0;
            end
        endcase
    end

    // Output slot: capture on a free slot, otherwise drop and flag overrun
    always_comb begin
        slot_free_s = !valid_r || outReady;
        valid_s     = valid_r && !outReady;
        level_s     = level_r;
        count_s     = count_r;
        sat_s       = sat_r;
        overrun_s   = overrun_r;
        if (edge_s && slot_free_s) begin
            valid_s = 1'b1;
            level_s = prev_r;
            count_s = cnt_r;
            sat_s   = (cnt_r == CNT_MAX);
        end else begin
            valid_s = valid_r && !outReady;
        end
        // A drop wins over a simultaneous clear so no loss goes unreported
        if (edge_s && !slot_free_s) begin
            overrun_s = 1'b1;
        end else if (clrOvr) begin
            overrun_s = 1'b0;
        end else begin
            overrun_s = overrun_r;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_INIT;
            cnt_r     <= {CNT_WIDTH{1'b0}};
            prev_r    <= 1'b0;
            valid_r   <= 1'b0;
            level_r   <= 1'b0;
            count_r   <= {CNT_WIDTH{1'b0}};
            sat_r     <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            prev_r    <= prev_s;
            valid_r   <= valid_s;
            level_r   <= level_s;
            count_r   <= count_s;
            sat_r     <= sat_s;
            overrun_r <= overrun_s;
        end
    end

    assign outValid = valid_r;
    assign outLevel = level_r;
    assign outCount = count_r;
    assign outSat   = sat_r;
    assign overrun  = overrun_r;

endmodule

// File: tb/tb_pulse_timer.sv
// Directed bench for pulse_timer: a 16-bit and a 4-bit instance share stimulus
// and are checked against hand-computed expectations.
module tb_pulse_timer;

    logic        clk;
    logic        rst;
    logic        en;
    logic        bitIn;
    logic        clrOvr;
    logic        outReady;

    logic        a_valid, a_level, a_sat, a_ovr;
    logic [15:0] a_count;
    logic        b_valid, b_level, b_sat, b_ovr;
    logic [3:0]  b_count;

    int checks = 0;
    int errors = 0;

    pulse_timer #(.CNT_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .en(en), .bitIn(bitIn), .clrOvr(clrOvr),
        .outValid(a_valid), .outReady(outReady), .outLevel(a_level),
        .outCount(a_count), .outSat(a_sat), .overrun(a_ovr)
    );

    pulse_timer #(.CNT_WIDTH(4)) dut_b (
        .clk(clk), .rst(rst), .en(en), .bitIn(bitIn), .clrOvr(clrOvr),
        .outValid(b_valid), .outReady(outReady), .outLevel(b_level),
        .outCount(b_count), .outSat(b_sat), .overrun(b_ovr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_valid(input string tag, input logic v);
        chk({tag, " a.valid"}, 32'(a_valid), 32'(v));
        chk({tag, " b.valid"}, 32'(b_valid), 32'(v));
    endtask

    task automatic chk_data(input string tag, input logic l, input int c16, input logic s16,
                            input int c4, input logic s4);
        chk_valid(tag, 1'b1);
        chk({tag, " a.level"}, 32'(a_level), 32'(l));
        chk({tag, " a.count"}, 32'(a_count), 32'(c16));
        chk({tag, " a.sat"},   32'(a_sat),   32'(s16));
        chk({tag, " b.level"}, 32'(b_level), 32'(l));
        chk({tag, " b.count"}, 32'(b_count), 32'(c4));
        chk({tag, " b.sat"},   32'(b_sat),   32'(s4));
    endtask

    task automatic chk_ovr(input string tag, input logic o);
        chk({tag, " a.overrun"}, 32'(a_ovr), 32'(o));
        chk({tag, " b.overrun"}, 32'(b_ovr), 32'(o));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic b);
        bitIn = b;
        en    = 1'b1;
        tick();
        en    = 1'b0;
    endtask

    initial begin
        rst      = 1'b0;
        en       = 1'b0;
        bitIn    = 1'b0;
        clrOvr   = 1'b0;
        outReady = 1'b1;

        // Reset state
        #2;
        chk_valid("reset", 1'b0);
        chk_ovr("reset", 1'b0);
        chk("reset a.count", 32'(a_count), 32'd0);
        chk("reset b.level", 32'(b_level), 32'd0);
        tick();
        tick();
        rst = 1'b1;

        // Basic sequence: low 10, high 5, low 7, high
        en = 1'b1;
        bitIn = 1'b0;
        repeat (10) tick();
        chk_valid("initial low", 1'b0);
        bitIn = 1'b1;
        repeat (5) tick();
        chk_valid("partial phase", 1'b0);
        bitIn = 1'b0;
        tick();
        chk_data("high5", 1'b1, 5, 1'b0, 5, 1'b0);
        repeat (6) tick();
        chk_valid("consumed", 1'b0);
        bitIn = 1'b1;
        tick();
        chk_data("low7", 1'b0, 7, 1'b0, 7, 1'b0);
        tick();
        chk_valid("consumed2", 1'b0);

        // Sparse enable; bitIn toggles between strobes must be ignored
        strobe(1'b0);
        chk_data("pre-sparse", 1'b1, 2, 1'b0, 2, 1'b0);
        bitIn = 1'b1;
        repeat (3) tick();
        strobe(1'b1);
        chk_data("min count", 1'b0, 1, 1'b0, 1, 1'b0);
        bitIn = 1'b0;
        repeat (3) tick();
        strobe(1'b1);
        bitIn = 1'b0;
        repeat (3) tick();
        strobe(1'b1);
        bitIn = 1'b0;
        repeat (3) tick();
        chk_valid("sparse hold", 1'b0);
        strobe(1'b0);
        chk_data("sparse", 1'b1, 3, 1'b0, 3, 1'b0);

        // Saturation: 20-sample high phase, then 2-sample low phase
        en = 1'b1;
        bitIn = 1'b1;
        tick();
        repeat (19) tick();
        bitIn = 1'b0;
        tick();
        chk_data("long high", 1'b1, 20, 1'b0, 15, 1'b1);
        tick();
        bitIn = 1'b1;
        tick();
        chk_data("after sat", 1'b0, 2, 1'b0, 2, 1'b0);

        // Consume and capture in the same cycle
        bitIn = 1'b0;
        tick();
        chk_data("back-to-back", 1'b1, 1, 1'b0, 1, 1'b0);
        chk_ovr("back-to-back", 1'b0);

        // Back-pressure: three dropped measurements
        outReady = 1'b0;
        tick();
        tick();
        bitIn = 1'b1;
        tick();
        chk_ovr("drop1", 1'b1);
        bitIn = 1'b0;
        tick();
        bitIn = 1'b1;
        tick();
        chk_data("held", 1'b1, 1, 1'b0, 1, 1'b0);
        chk_ovr("drop3", 1'b1);
        clrOvr = 1'b1;
        tick();
        clrOvr = 1'b0;
        chk_ovr("clear", 1'b0);
        clrOvr = 1'b1;
        bitIn = 1'b0;
        tick();
        clrOvr = 1'b0;
        chk_ovr("clear vs drop", 1'b1);
        chk_data("held2", 1'b1, 1, 1'b0, 1, 1'b0);
        outReady = 1'b1;
        tick();
        chk_valid("released", 1'b0);
        bitIn = 1'b1;
        tick();
        chk_data("post-drop", 1'b0, 2, 1'b0, 2, 1'b0);

        // Asynchronous reset mid-phase with a held measurement
        outReady = 1'b0;
        tick();
        chk_valid("pre-reset", 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk_valid("async reset", 1'b0);
        chk_ovr("async reset", 1'b0);
        chk("async reset a.count", 32'(a_count), 32'd0);
        chk("async reset b.count", 32'(b_count), 32'd0);
        chk("async reset a.level", 32'(a_level), 32'd0);
        chk("async reset a.sat",   32'(a_sat),   32'd0);
        #1;
        rst = 1'b1;
        outReady = 1'b1;
        tick();
        chk_valid("after reset init", 1'b0);
        bitIn = 1'b0;
        tick();
        chk_valid("after reset edge1", 1'b0);
        tick();
        tick();
        bitIn = 1'b1;
        tick();
        chk_data("after reset edge2", 1'b0, 3, 1'b0, 3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
